lsu_bus_master: RTL
===================

Name: lsu_bus_master

Overview:
Load/store initiator that drives the core's data-bus request interface (data_req/addr/wmask/size/wdata, rdata, stall, uncache) toward the DPI-C SRAM model or any other bus responder. It accepts one memory op at a time from the pipeline over a valid/ready handshake and generates the byte-lane write mask and shifted write data. It waits out data_stall, then returns the lane-aligned, sign/zero-extended load result or a store acknowledge on a valid/ready response channel.

Parameters:
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, bus data width; only 32 or 64 are legal, and any other value must fail elaboration.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low (asserted when 0, sampled on posedge clk)
op_valid  in  1  pipeline presents an op
op_ready  out  1  block can accept an op
op_addr  in  ADDR_WIDTH  byte address
op_wdata  in  DATA_WIDTH  store data, right-justified
op_size  in  2  0=byte 1=half 2=word 3=dword (64-bit only)
op_store  in  1  1=store 0=load
op_signed  in  1  sign-extend load result
op_uncache  in  1  uncached access
resp_valid  out  1  response available
resp_ready  in  1  pipeline consumes response
resp_rdata  out  DATA_WIDTH  extended load data (0 for stores/errors)
resp_err  out  1  misaligned or illegal size
data_req  out  1  bus request
data_addr  out  ADDR_WIDTH  bus address (full byte address)
data_wmask  out  DATA_WIDTH/8  byte write mask (all zero = read)
data_size  out  2  access size
data_wdata  out  DATA_WIDTH  lane-shifted write data
data_rdata  in  DATA_WIDTH  naturally aligned bus word containing addr; valid the cycle after read acceptance, held until the next accepted read
data_stall  in  1  responder not accepting this cycle
data_uncache  out  1  registered copy of op_uncache

Behaviour:
- Reset values: state=IDLE, op_ready=1, data_req=0, data_wmask=0, data_addr=0, data_wdata=0, data_size=0, data_uncache=0, resp_valid=0, resp_err=0, resp_rdata=0.
- Bus rule: a request is accepted on a posedge where data_req=1 and data_stall=0. All data_* outputs stay stable while data_req=1 and data_stall=1.
- FSM states are IDLE, REQ, RESP.
- IDLE: op_ready=1. On op_valid, latch the op into holding registers and compute off = addr mod (DATA_WIDTH/8).
  - Misaligned op (half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0) or size 3 when DATA_WIDTH=32: go to RESP with err=1 and issue no bus request.
  - Otherwise go to REQ.
- REQ: data_req=1 with registered outputs.
  - Store: wmask = ((1<<(1<<size))-1) << off, and wdata = op_wdata << (8*off).
  - Load: wmask = 0, and wdata is don't-care (driven 0).
  - When the request is accepted, go to RESP and drop data_req to 0 the next cycle.
  - If data_stall is held indefinitely, REQ is held indefinitely; there is no timeout.
- RESP: resp_valid=1.
  - Load: resp_rdata = data_rdata >> (8*off), truncated to 8<<size bits, then sign-extended if op_signed else zero-extended. It is computed combinationally from the held data_rdata.
  - Store or err: resp_rdata=0.
  - When resp_valid && resp_ready, go to IDLE. op_ready is 0 throughout REQ and RESP (no overlap).
- Latency with no stall: op accepted at edge T, data_req high in cycle T..T+1, bus accepts at edge T+1, resp_valid in cycle T+1..T+2.
  - Each stalled cycle adds 1.
  - An error op responds the cycle after acceptance.
- Minimum op spacing: 3 cycles (IDLE, REQ, RESP).
- Reset asserted in any state: return to IDLE next edge with reset values. A stalled, unaccepted request is abandoned, and a pending response is discarded.
- data_uncache equals the latched op_uncache whenever data_req=1.

Decomposition:
- Shared package lsu_pkg holds:
  - mem_size_e (SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3);
  - lsu_state_e (IDLE, REQ, RESP);
  - the lsu_op_t struct (addr, wdata, size, store, signed, uncache);
  - the function size_bytes(size).
- One natural sub-module, lsu_lane_align. It is purely combinational and contains:
  - the store path: wmask/wdata generation from size and off;
  - the load path: extract and extend from data_rdata.
- The FSM and holding registers stay in lsu_bus_master.

Test Plan:
1. Byte store: addr=0x1003, wdata=0xAB, size=0, no stall -> data_req for 1 cycle with wmask=4'b1000, wdata=0xAB000000; resp_valid next cycle with rdata=0, err=0.
2. Signed half load: addr=0x2002, size=1, signed=1, data_rdata=0x80F01234 -> resp_rdata=0xFFFF80F0. Repeat with signed=0 -> 0x000080F0.
3. Stall: word load at 0x3000, data_stall=1 for 3 cycles -> data_req and all data_* stable for 4 cycles; resp_valid appears exactly 1 cycle after stall drops, with rdata equal to data_rdata.
4. Misaligned word store at 0x4002 -> data_req never asserted; resp_valid 1 cycle after op acceptance with err=1, rdata=0. Size 3 at DATA_WIDTH=32 gives the same response.
5. Response backpressure: word load completes, resp_ready=0 for 2 cycles -> resp_valid and resp_rdata held, op_ready=0, no new data_req; the op is accepted only after the resp_ready handshake.
6. Reset: assert rst=0 during a stalled REQ -> next cycle data_req=0, resp_valid=0, op_ready=1. After release, a fresh byte load at 0x5001 returns the correct lane.

Source files
------------

// File: rtl/lsu_bus_master_pkg.sv
// Shared types for the load/store bus master.
// Sizes, FSM states, the latched op bundle and size helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // Fields sized for the widest legal bus; the top slices them down.
    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] wdata;
        mem_size_e   size;
        logic        store;
        logic        is_signed;
        logic        uncache;
    } lsu_op_t;

    function automatic logic [3:0] size_bytes(input mem_size_e sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Data-bus request/response signals between the LSU and a responder.
// master = LSU side, slave = memory/responder side.
interface lsu_bus_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    data_req;
    logic [ADDR_WIDTH-1:0]   data_addr;
    logic [DATA_WIDTH/8-1:0] data_wmask;
    logic [1:0]              data_size;
    logic [DATA_WIDTH-1:0]   data_wdata;
    logic                    data_uncache;
    logic [DATA_WIDTH-1:0]   data_rdata;
    logic                    data_stall;

    modport master (
        output data_req, data_addr, data_wmask, data_size,
        output data_wdata, data_uncache,
        input  data_rdata, data_stall
    );

    modport slave (
        input  data_req, data_addr, data_wmask, data_size,
        input  data_wdata, data_uncache,
        output data_rdata, data_stall
    );
endinterface

// File: rtl/lsu_bus_master_lane_align.sv
// Byte-lane alignment: store mask/data shift and load extract/extend.
// Purely combinational; off is the byte offset within the bus word.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NB         = DATA_WIDTH / 8,
    parameter int OFFW       = $clog2(DATA_WIDTH / 8)
) (
    input  mem_size_e             st_size,
    input  logic [OFFW-1:0]       st_off,
    input  logic [DATA_WIDTH-1:0] st_wdata,
    output logic [NB-1:0]         st_wmask,
    output logic [DATA_WIDTH-1:0] st_wdata_sh,
    input  mem_size_e             ld_size,
    input  logic [OFFW-1:0]       ld_off,
    input  logic                  ld_signed,
    input  logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [15:0]           base;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] lowm;
    logic [DATA_WIDTH-1:0] topb;
    logic [6:0]            nbits;
    logic                  sb;

    // Store path: contiguous byte mask and data moved up to the lane.
    always_comb begin
        base        = (16'd1 << size_bytes(st_size)) - 16'd1;
        st_wmask    = NB'(base) << st_off;
        st_wdata_sh = st_wdata << {st_off, 3'b000};
    end

    // Load path: bring lane down, keep 8<<size bits, then extend.
    always_comb begin
        sh    = ld_rdata >> {ld_off, 3'b000};
        nbits = {size_bytes(ld_size), 3'b000};
        if (nbits > 7'(DATA_WIDTH)) begin
            nbits = 7'(DATA_WIDTH);
        end
        lowm    = {DATA_WIDTH{1'b1}} >> (7'(DATA_WIDTH) - nbits);
        topb    = lowm ^ (lowm >> 1);
        sb      = |(sh & topb);
        ld_data = (ld_signed && sb) ? (sh | ~lowm) : (sh & lowm);
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store initiator: one op at a time, IDLE -> REQ -> RESP.
// Holds the op, drives registered bus outputs, returns extended data.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [ADDR_WIDTH-1:0] op_addr,
    input  logic [DATA_WIDTH-1:0] op_wdata,
    input  logic [1:0]            op_size,
    input  logic                  op_store,
    input  logic                  op_signed,
    input  logic                  op_uncache,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    lsu_bus_master_if.master      bus
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("lsu_bus_master: DATA_WIDTH must be 32 or 64");
    end

    lsu_state_e            state_q;
    lsu_state_e            state_d;
    lsu_op_t               op_q;
    logic                  err_q;
    mem_size_e             in_sz;
    logic [3:0]            in_nbytes;
    logic                  in_bad;
    logic [NB-1:0]         st_wmask;
    logic [DATA_WIDTH-1:0] st_wdata_sh;
    logic [DATA_WIDTH-1:0] ld_data;

    assign in_sz     = mem_size_e'(op_size);
    assign in_nbytes = size_bytes(in_sz);
    assign in_bad    = (|(op_addr[2:0] & 3'(in_nbytes - 4'd1)))
                    || (in_sz == SZ_D && DATA_WIDTH == 32);

    lsu_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .st_size     (in_sz),
        .st_off      (op_addr[OFFW-1:0]),
        .st_wdata    (op_wdata),
        .st_wmask    (st_wmask),
        .st_wdata_sh (st_wdata_sh),
        .ld_size     (op_q.size),
        .ld_off      (op_q.addr[OFFW-1:0]),
        .ld_signed   (op_q.is_signed),
        .ld_rdata    (bus.data_rdata),
        .ld_data     (ld_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/response outputs.
    always_comb begin
        state_d    = state_q;
        op_ready   = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        unique case (state_q)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    state_d = in_bad ? RESP : REQ;
                end
            end
            REQ: begin
                if (!bus.data_stall) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !op_q.store) begin
                    resp_rdata = ld_data;
                end
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Op latch and registered bus outputs; held while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q             <= '0;
            err_q            <= 1'b0;
            bus.data_req     <= 1'b0;
            bus.data_addr    <= '0;
            bus.data_wmask   <= '0;
            bus.data_size    <= '0;
            bus.data_wdata   <= '0;
            bus.data_uncache <= 1'b0;
        end else if (state_q == IDLE && op_valid) begin
            op_q.addr      <= 64'(op_addr);
            op_q.wdata     <= 64'(op_wdata);
            op_q.size      <= in_sz;
            op_q.store     <= op_store;
            op_q.is_signed <= op_signed;
            op_q.uncache   <= op_uncache;
            err_q          <= in_bad;
            if (!in_bad) begin
                bus.data_req     <= 1'b1;
                bus.data_addr    <= op_addr;
                bus.data_size    <= op_size;
                bus.data_uncache <= op_uncache;
                bus.data_wmask   <= op_store ? st_wmask : '0;
                bus.data_wdata   <= op_store ? st_wdata_sh : '0;
            end
        end else if (state_q == REQ && !bus.data_stall) begin
            bus.data_req <= 1'b0;
        end
    end

endmodule
